sram_rw_initiator: RTL

SRAM_RW_INITIATOR -- requirements
Module: sram_rw_initiator

---
 rtl/sram_rw_initiator.sv | 129 ++++++++++++
 1 files changed

// File: rtl/sram_rw_initiator.sv
// Request/response front end for a single-port SRAM with a 2-cycle read path.
// Reads are tracked through a 2-stage in-flight pipe and land in a credit-protected response FIFO.
`timescale 1ns/1ps
module sram_rw_initiator #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0,
    input  logic                  read_valid,
    output logic                  err
);

    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic                  issue_q, issue_d;
    logic                  cap_q, cap_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  csb_q, csb_d;
    logic                  web_q, web_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic                  err_q, err_d;
    logic                  rst_mask_q;
    logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];

    logic [CNT_W:0]        credits;
    logic                  accept;
    logic                  push;
    logic                  pop;

    // Every read in flight already owns a FIFO slot, so the FIFO can never overflow.
    assign credits   = {1'b0, count_q} + (CNT_W+1)'(issue_q) + (CNT_W+1)'(cap_q);
    assign req_ready = ~rst0 & (credits < (CNT_W+1)'(RSP_DEPTH));
    assign accept    = req_valid & req_ready;
    assign push      = cap_q;
    assign rsp_valid = (count_q != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign rsp_rdata = mem_q[rd_ptr_q];

    assign csb0 = csb_q;
    assign web0 = web_q;
    assign addr0 = addr_q;
    assign din0 = din_q;
    assign err = err_q;

    always_comb begin
        issue_d  = accept & ~req_we;
        cap_d    = issue_q;
        csb_d    = 1'b1;
        web_d    = 1'b1;
        addr_d   = addr_q;
        din_d    = din_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (accept) begin
            csb_d  = 1'b0;
            web_d  = ~req_we;
            addr_d = req_addr;
            din_d  = req_wdata;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // A strobe for a read issued just before reset is expected on the first edge out of reset.
        err_d = err_q | (~rst_mask_q & (read_valid != cap_q));
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            issue_q    <= 1'b0;
            cap_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            csb_q      <= 1'b1;
            web_q      <= 1'b1;
            addr_q     <= '0;
            din_q      <= '0;
            err_q      <= 1'b0;
            rst_mask_q <= 1'b1;
        end else begin
            issue_q    <= issue_d;
            cap_q      <= cap_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            csb_q      <= csb_d;
            web_q      <= web_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            err_q      <= err_d;
            rst_mask_q <= 1'b0;
        end
    end

    always_ff @(posedge clk0) begin
        if (!rst0 && push) begin
            mem_q[wr_ptr_q] <= dout0;
        end
    end

endmodule
